md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit for the P6 five-stage pipeline, sitting in the E stage beside the ALU. It executes mult/multu/div/divu over a fixed multi-cycle latency and owns the HI/LO registers, including mthi/mtlo writes and the mfhi/mflo read port. It produces the `Busy` flag that the hazard/forwarding control unit combines with `Start` to stall any HI/LO-class instruction held in D.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: Busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: Busy cycles for div/divu.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `Start` in 1: one-cycle pulse while a mult/multu/div/divu is in E.
- `MDOp` in 3: operation code.
  - 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
- `A` in 32: rs operand, forwarded value.
- `B` in 32: rt operand, forwarded value.
- `HiLoSel` in 1: read select for `MDOut`; 1 selects HI, 0 selects LO.
- `Busy` out 1: high while an operation is in flight; registered.
- `HI` out 32: current HI register.
- `LO` out 32: current LO register.
- `MDOut` out 32: combinational `HiLoSel ? HI : LO`, used for mfhi/mflo.

## Operation

- State registers: `HI`, `LO`, 4-bit down-counter `cnt`, pending results `pHI` and `pLO`. `Busy = (cnt != 0)`.
- Launch: a rising edge with `Start=1`, `cnt==0` and `MDOp` in 1..4:
  - loads `cnt` with `MULT_CYCLES` (ops 1,2) or `DIV_CYCLES` (ops 3,4);
  - latches the computed result into `pHI`/`pLO`.
- Arithmetic:
  - MULT: `{pHI,pLO} = $signed(A)*$signed(B)`, full 64 bits.
  - MULTU: the same product, unsigned.
  - DIV: `pLO` = signed quotient truncated toward zero; `pHI` = remainder, carrying the sign of the dividend.
  - DIVU: `pLO` = unsigned quotient, `pHI` = unsigned remainder.
- Overflow case: 0x80000000 div 0xFFFFFFFF gives `pLO=0x80000000`, `pHI=0`.
- Divide by zero (B==0, ops 3/4): the operation still runs the full `DIV_CYCLES` Busy window, but HI/LO are left unchanged at completion.
- Countdown: each edge with `cnt!=0` decrements `cnt`. On the edge where `cnt` goes from 1 to 0, `HI<=pHI` and `LO<=pLO` (subject to the divide-by-zero rule).
- mthi/mtlo: an edge with `MDOp==5` writes `HI<=A`; `MDOp==6` writes `LO<=A`. `Start` is irrelevant to these ops.
- While `Busy`: any `Start` and any MTHI/MTLO is ignored. The hazard unit prevents this case; the ignore behaviour is the defined fallback.
- `Start` with `MDOp` outside 1..4: ignored.
- Reset (asynchronous, any time, including mid-operation):
  - `HI=0`, `LO=0`, `cnt=0`, `pHI=0`, `pLO=0`, so `Busy=0` and `MDOut=0` immediately;
  - the in-flight operation is discarded.

## Timing

- Let edge t sample the `Start` pulse.
- `Busy` is high during cycles t+1 through t+N, with N = `MULT_CYCLES` or `DIV_CYCLES`.
- New HI/LO are visible from cycle t+N+1, the same cycle `Busy` falls.
- A new `Start` is accepted on the edge that ends cycle t+N+1 or later. Back-to-back operations therefore have a minimum spacing of N+1 cycles.
- The hazard unit stalls on `Start|Busy`, so the Start cycle and the Busy window are both covered.
- An mfhi/mflo reaching E in cycle t+N+1 reads the new value through `MDOut` with no bypass.
- MTHI/MTLO results are visible in the cycle after their edge.
- `MDOut` has zero latency from `HiLoSel`.

## Test plan

- Reset: reset pulse mid-cycle → `HI`, `LO`, `MDOut`, `Busy` are all 0 immediately, without waiting for a clock edge.
- MULT with A=0xFFFFFFFD (−3), B=5 → Busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU with A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV with A=0xFFFFFFF9 (−7), B=2 → Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with B=0 after MTHI A=0x12345678 and MTLO A=0x9ABCDEF0 → Busy for 10 cycles, HI/LO unchanged. `HiLoSel=1` gives MDOut=0x12345678; `HiLoSel=0` gives 0x9ABCDEF0.
- Boundary cases:
  - `Start`+MULT asserted during the 3rd Busy cycle of a DIV → ignored; DIV completes normally.
  - `reset` asserted in Busy cycle 4 of a MULT → Busy drops at once and HI/LO stay 0.
  - DIV 0x80000000 by 0xFFFFFFFF → LO=0x80000000, HI=0.

Source files
------------

// File: rtl/md_unit.sv
// md_unit -- multiply/divide unit for the E stage of the five-stage pipeline.
//
// Runs mult/multu/div/divu over a fixed multi-cycle Busy window and owns the
// HI/LO register pair, including the mthi/mtlo writes and the mfhi/mflo read
// mux. The result is computed when the operation launches, held in pHI/pLO,
// and committed to HI/LO on the edge where the countdown reaches zero.
//
// Ports:
//   clk      in   1   clock, rising edge
//   reset    in   1   asynchronous active-high reset
//   Start    in   1   pulse while a mult/multu/div/divu is in E
//   MDOp     in   3   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
//   A        in  32   rs operand
//   B        in  32   rt operand
//   HiLoSel  in   1   MDOut select: 1 = HI, 0 = LO
//   Busy     out  1   operation in flight
//   HI       out 32   HI register
//   LO       out 32   LO register
//   MDOut    out 32   HiLoSel ? HI : LO
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HiLoSel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    md_op_e      op;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] phi_q, phi_d, plo_q, plo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        nowr_q, nowr_d;   // divide-by-zero: suppress the commit

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, div_b, q_mag, r_mag, quo, rem;
    logic        is_signed_div;

    assign op = md_op_e'(MDOp);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed division is done on magnitudes so 0x80000000 / -1 wraps to
    // 0x80000000 with remainder 0 instead of overflowing the divider.
    // A zero divisor is replaced by 1 only to keep the divider defined; its
    // result is never committed.
    always_comb begin
        is_signed_div = (op == OP_DIV);
        a_mag = (is_signed_div && A[31]) ? -A : A;
        b_mag = (is_signed_div && B[31]) ? -B : B;
        div_b = (b_mag == '0) ? 32'd1 : b_mag;
        q_mag = a_mag / div_b;
        r_mag = a_mag % div_b;
        quo   = (is_signed_div && (A[31] ^ B[31])) ? -q_mag : q_mag;
        rem   = (is_signed_div && A[31]) ? -r_mag : r_mag;
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        phi_d  = phi_q;
        plo_d  = plo_q;
        cnt_d  = cnt_q;
        nowr_d = nowr_q;
        if (cnt_q != '0) begin
            // Busy: Start and MTHI/MTLO are ignored.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1 && !nowr_q) begin
                hi_d = phi_q;
                lo_d = plo_q;
            end
        end else if (Start && (op == OP_MULT || op == OP_MULTU)) begin
            cnt_d  = 4'(MULT_CYCLES);
            nowr_d = 1'b0;
            {phi_d, plo_d} = (op == OP_MULT) ? prod_s : prod_u;
        end else if (Start && (op == OP_DIV || op == OP_DIVU)) begin
            cnt_d  = 4'(DIV_CYCLES);
            nowr_d = (B == '0);
            phi_d  = rem;
            plo_d  = quo;
        end else if (op == OP_MTHI) begin
            hi_d = A;
        end else if (op == OP_MTLO) begin
            lo_d = A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            phi_q  <= '0;
            plo_q  <= '0;
            cnt_q  <= '0;
            nowr_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            phi_q  <= phi_d;
            plo_q  <= plo_d;
            cnt_q  <= cnt_d;
            nowr_q <= nowr_d;
        end
    end

    assign Busy  = (cnt_q != '0);
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign MDOut = HiLoSel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- directed bench for md_unit: reset behaviour, each arithmetic
// op with hand-computed results, Busy window length, divide-by-zero, MTHI/MTLO,
// ignored Start during Busy, reset mid-operation and the signed overflow case.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiLoSel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;

    int unsigned vectors;
    int unsigned miscompares;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .MDOp    (MDOp),
        .A       (A),
        .B       (B),
        .HiLoSel (HiLoSel),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO),
        .MDOut   (MDOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        tick();
        Start = 1'b0;
        MDOp  = 3'd0;
    endtask

    task automatic write_hilo(input logic [2:0] op, input logic [31:0] a);
        MDOp = op;
        A    = a;
        tick();
        MDOp = 3'd0;
    endtask

    // Expects Busy high for exactly n cycles following the launch edge.
    task automatic busy_window(input string tag, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
            tick();
        end
        check({tag, "_idle"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b1;
        Start   = 1'b0;
        MDOp    = 3'd0;
        A       = '0;
        B       = '0;
        HiLoSel = 1'b0;

        // Reset state
        #12;
        reset = 1'b0;
        tick();
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);

        // MTHI/MTLO, then an asynchronous reset mid-cycle
        write_hilo(3'd5, 32'h11111111);
        check("mthi", HI, 32'h11111111);
        write_hilo(3'd6, 32'h22222222);
        check("mtlo", LO, 32'h22222222);
        HiLoSel = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        check("arst_mdout", MDOut, 32'd0);
        check("arst_busy", {31'd0, Busy}, 32'd0);
        reset = 1'b0;
        HiLoSel = 1'b0;
        tick();

        // MULT -3 * 5 = -15
        launch(3'd1, 32'hFFFFFFFD, 32'd5);
        check("mult_hold_hi", HI, 32'd0);
        busy_window("mult", 5);
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFF1);

        // MULTU 0xFFFFFFFF * 2
        launch(3'd2, 32'hFFFFFFFF, 32'd2);
        busy_window("multu", 5);
        check("multu_hi", HI, 32'h00000001);
        check("multu_lo", LO, 32'hFFFFFFFE);

        // DIV -7 / 2 -> q=-3, r=-1
        launch(3'd3, 32'hFFFFFFF9, 32'd2);
        busy_window("div", 10);
        check("div_lo", LO, 32'hFFFFFFFD);
        check("div_hi", HI, 32'hFFFFFFFF);

        // DIVU by zero leaves HI/LO untouched
        write_hilo(3'd5, 32'h12345678);
        write_hilo(3'd6, 32'h9ABCDEF0);
        launch(3'd4, 32'h00000064, 32'd0);
        busy_window("divz", 10);
        HiLoSel = 1'b1;
        #1;
        check("divz_mdout_hi", MDOut, 32'h12345678);
        HiLoSel = 1'b0;
        #1;
        check("divz_mdout_lo", MDOut, 32'h9ABCDEF0);
        tick();

        // Reserved op with Start does nothing
        launch(3'd7, 32'd1, 32'd1);
        check("rsvd_busy", {31'd0, Busy}, 32'd0);
        check("rsvd_hi", HI, 32'h12345678);

        // DIV 100 / 7 with a MULT Start in Busy cycle 3 and an MTHI in cycle 5
        launch(3'd3, 32'd100, 32'd7);
        for (int unsigned i = 0; i < 10; i++) begin
            check("ign_busy", {31'd0, Busy}, 32'd1);
            Start = (i == 2);
            MDOp  = (i == 2) ? 3'd1 : ((i == 4) ? 3'd5 : 3'd0);
            A     = (i == 2) ? 32'd3 : 32'h0000DEAD;
            B     = 32'd3;
            tick();
        end
        Start = 1'b0;
        MDOp  = 3'd0;
        check("ign_idle", {31'd0, Busy}, 32'd0);
        check("ign_lo", LO, 32'd14);
        check("ign_hi", HI, 32'd2);

        // Reset during Busy cycle 4 of a MULT discards it
        launch(3'd1, 32'd2, 32'd3);
        tick();
        tick();
        tick();
        check("mrst_pre_busy", {31'd0, Busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mrst_busy", {31'd0, Busy}, 32'd0);
        check("mrst_hi", HI, 32'd0);
        check("mrst_lo", LO, 32'd0);
        reset = 1'b0;
        for (int unsigned i = 0; i < 6; i++) tick();
        check("mrst_after_busy", {31'd0, Busy}, 32'd0);
        check("mrst_after_hi", HI, 32'd0);
        check("mrst_after_lo", LO, 32'd0);

        // Signed overflow case
        launch(3'd3, 32'h80000000, 32'hFFFFFFFF);
        busy_window("ovf", 10);
        check("ovf_lo", LO, 32'h80000000);
        check("ovf_hi", HI, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
